// File: rtl/spi_xip_bridge_apb.sv
// APB XIP flash bridge over a compact Wishbone SPI master (spi_top).
// Define XIP_PREFETCH_EN for a one-word XIP read buffer.

module spi_top #(
  parameter int SS_NUM = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [4:0]        wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_int_o,
  output logic [SS_NUM-1:0] ss_pad_o,
  output logic              sclk_pad_o,
  output logic              mosi_pad_o,
  input  logic              miso_pad_i
);

  logic [127:0]      shreg;
  logic [13:0]       ctrl;
  logic [15:0]       divider;
  logic [SS_NUM-1:0] ss;
  logic              tip;
  logic              sck;
  logic              mosi;
  logic              irq;
  logic              ack;
  logic [15:0]       cnt;
  logic [7:0]        edges;
  logic [6:0]        msb;
  logic              req;
  logic              wr;
  logic              tick;
  logic              tx_edge;
  logic              rx_edge;
  logic [31:0]       rd_mux;
  logic              unused_sel;

  // CHAR_LEN of 0 wraps to 127, i.e. a 128-bit transfer
  assign msb        = ctrl[6:0] - 7'd1;
  assign req        = wb_stb_i & wb_cyc_i & ~ack;
  assign wr         = req & wb_we_i;
  assign tick       = tip & (cnt == 16'd0);
  assign tx_edge    = tick & (ctrl[10] ? sck : ~sck);
  assign rx_edge    = tick & (ctrl[9] ? sck : ~sck);
  assign unused_sel = ^wb_sel_i;

  always_comb begin
    rd_mux = '0;
    case (wb_adr_i[4:2])
      3'd0:    rd_mux = shreg[31:0];
      3'd1:    rd_mux = shreg[63:32];
      3'd2:    rd_mux = shreg[95:64];
      3'd3:    rd_mux = shreg[127:96];
      3'd4:    rd_mux = {18'd0, ctrl[13:9], tip, ctrl[7:0]};
      3'd5:    rd_mux = {16'd0, divider};
      3'd6:    rd_mux = 32'(ss);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shreg    <= '0;
      ctrl     <= '0;
      divider  <= '0;
      ss       <= '0;
      tip      <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      irq      <= 1'b0;
      ack      <= 1'b0;
      cnt      <= '0;
      edges    <= '0;
      wb_dat_o <= '0;
    end else begin
      ack <= req;
      if (req) begin
        wb_dat_o <= rd_mux;
        irq      <= 1'b0;
      end
      if (wr && wb_adr_i[4:2] == 3'd6)
        ss <= wb_dat_i[SS_NUM-1:0];
      if (wr && !tip) begin
        case (wb_adr_i[4:2])
          3'd0, 3'd1, 3'd2, 3'd3:
            shreg[{wb_adr_i[3:2], 5'd0} +: 32] <= wb_dat_i;
          3'd4: begin
            ctrl <= wb_dat_i[13:0];
            if (wb_dat_i[8]) begin
              tip   <= 1'b1;
              cnt   <= divider;
              edges <= '0;
            end
          end
          3'd5:    divider <= wb_dat_i[15:0];
          default: ;
        endcase
      end
      if (tick) begin
        cnt   <= divider;
        sck   <= ~sck;
        edges <= edges + 8'd1;
        if (tx_edge)
          mosi <= shreg[msb];
        if (rx_edge)
          shreg <= {shreg[126:0], miso_pad_i};
        if (edges == {msb, 1'b1}) begin
          tip <= 1'b0;
          irq <= ctrl[12];
        end
      end else if (tip) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  assign ss_pad_o   = ~(ss & (ctrl[13] ? {SS_NUM{tip}} : {SS_NUM{1'b1}}));
  assign sclk_pad_o = sck;
  assign mosi_pad_o = mosi;
  assign wb_ack_o   = ack;
  assign wb_err_o   = 1'b0;
  assign wb_int_o   = irq;

endmodule

module spi_xip_bridge_apb #(
  parameter logic [31:0] FLASH_BASE = 32'h3000_0000,
  parameter logic [31:0] FLASH_END  = 32'h3fff_ffff,
  parameter logic [31:0] SPI_BASE   = 32'h1000_1000,
  parameter logic [31:0] SPI_END    = 32'h1000_1fff,
  parameter int          SS_NUM     = 8,
  parameter int          SS_IDX     = 0,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [15:0] DIVIDER    = 16'h0001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       in_paddr,
  input  logic              in_psel,
  input  logic              in_penable,
  input  logic [2:0]        in_pprot,
  input  logic              in_pwrite,
  input  logic [31:0]       in_pwdata,
  input  logic [3:0]        in_pstrb,
  output logic              in_pready,
  output logic [31:0]       in_prdata,
  output logic              in_pslverr,
  output logic              spi_sck,
  output logic [SS_NUM-1:0] spi_ss,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_irq_out
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_PASS  = 4'd1;
  localparam logic [3:0] S_ERR   = 4'd2;
  localparam logic [3:0] S_CMD   = 4'd3;
  localparam logic [3:0] S_DIV   = 4'd4;
  localparam logic [3:0] S_SS    = 4'd5;
  localparam logic [3:0] S_GO    = 4'd6;
  localparam logic [3:0] S_POLL  = 4'd7;
  localparam logic [3:0] S_RX    = 4'd8;
  localparam logic [3:0] S_UNSEL = 4'd9;
  localparam logic [3:0] S_RESP  = 4'd10;

  logic [3:0]  state;
  logic        gap;
  logic [21:0] xip_addr;
  logic [31:0] rx_word;
  logic        access;
  logic        in_spi;
  logic        in_flash;
  logic        hit;
  logic [4:0]  wb_adr;
  logic [31:0] wb_wdat;
  logic [31:0] wb_rdat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_ack;
  logic        wb_err;
  logic        unused_prot;

  assign access      = in_psel & in_penable;
  assign in_spi      = (in_paddr >= SPI_BASE) && (in_paddr <= SPI_END);
  assign in_flash    = (in_paddr >= FLASH_BASE) && (in_paddr <= FLASH_END);
  assign unused_prot = ^in_pprot;

`ifdef XIP_PREFETCH_EN
  logic pf_valid;
  assign hit = pf_valid && (xip_addr == in_paddr[23:2]);
`else
  assign hit = 1'b0;
`endif

  // gap drops stb/cyc for one cycle between sequenced transfers
  always_comb begin
    wb_adr  = '0;
    wb_wdat = '0;
    wb_sel  = 4'hf;
    wb_we   = 1'b0;
    wb_stb  = 1'b0;
    case (state)
      S_PASS: begin
        wb_adr  = in_paddr[4:0];
        wb_wdat = in_pwdata;
        wb_sel  = in_pstrb;
        wb_we   = in_pwrite;
        wb_stb  = access;
      end
      S_CMD: begin
        wb_adr  = 5'h04;
        wb_wdat = {READ_CMD, xip_addr, 2'b00};
        wb_we   = 1'b1;
        wb_stb  = ~gap;
      end
      S_DIV: begin
        wb_adr  = 5'h14;
        wb_wdat = {16'd0, DIVIDER};
        wb_we   = 1'b1;
        wb_stb  = ~gap;
      end
      S_SS: begin
        wb_adr  = 5'h18;
        wb_wdat = 32'd1 << SS_IDX;
        wb_we   = 1'b1;
        wb_stb  = ~gap;
      end
      S_GO: begin
        wb_adr  = 5'h10;
        wb_wdat = 32'h0000_0340;
        wb_we   = 1'b1;
        wb_stb  = ~gap;
      end
      S_POLL: begin
        wb_adr = 5'h10;
        wb_stb = ~gap;
      end
      S_RX: begin
        wb_adr = 5'h00;
        wb_stb = ~gap;
      end
      S_UNSEL: begin
        wb_adr = 5'h18;
        wb_we  = 1'b1;
        wb_stb = ~gap;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      gap      <= 1'b0;
      xip_addr <= '0;
      rx_word  <= '0;
    end else begin
      gap <= 1'b0;
      case (state)
        S_IDLE:
          if (access) begin
            if (in_spi) begin
              state <= S_PASS;
            end else if (in_flash && !in_pwrite) begin
              xip_addr <= in_paddr[23:2];
              state    <= hit ? S_RESP : S_CMD;
            end else begin
              state <= S_ERR;
            end
          end
        S_PASS:
          if (wb_ack) state <= S_IDLE;
        S_CMD:
          if (wb_ack) begin
            gap   <= 1'b1;
            state <= S_DIV;
          end
        S_DIV:
          if (wb_ack) begin
            gap   <= 1'b1;
            state <= S_SS;
          end
        S_SS:
          if (wb_ack) begin
            gap   <= 1'b1;
            state <= S_GO;
          end
        S_GO:
          if (wb_ack) begin
            gap   <= 1'b1;
            state <= S_POLL;
          end
        S_POLL:
          if (wb_ack) begin
            gap <= 1'b1;
            if (!wb_rdat[8]) state <= S_RX;
          end
        S_RX:
          if (wb_ack) begin
            gap     <= 1'b1;
            rx_word <= {wb_rdat[7:0], wb_rdat[15:8],
                        wb_rdat[23:16], wb_rdat[31:24]};
            state   <= S_UNSEL;
          end
        S_UNSEL:
          if (wb_ack) begin
            gap   <= 1'b1;
            state <= S_RESP;
          end
        default:
          state <= S_IDLE;
      endcase
    end
  end

`ifdef XIP_PREFETCH_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pf_valid <= 1'b0;
    end else begin
      if (state == S_IDLE && access && in_flash && !in_spi &&
          !in_pwrite && !hit)
        pf_valid <= 1'b0;
      if (state == S_UNSEL && wb_ack)
        pf_valid <= 1'b1;
      if (state == S_PASS && in_pwrite)
        pf_valid <= 1'b0;
    end
  end
`endif

  assign in_pready  = (state == S_ERR) || (state == S_RESP) ||
                      ((state == S_PASS) && wb_ack);
  assign in_pslverr = (state == S_ERR) || ((state == S_PASS) && wb_err);
  assign in_prdata  = (state == S_RESP) ? rx_word :
                      (state == S_PASS) ? wb_rdat : 32'd0;

  spi_top #(.SS_NUM(SS_NUM)) u_spi (
    .wb_clk_i   (clock),
    .wb_rst_i   (reset),
    .wb_adr_i   (wb_adr),
    .wb_dat_i   (wb_wdat),
    .wb_dat_o   (wb_rdat),
    .wb_sel_i   (wb_sel),
    .wb_we_i    (wb_we),
    .wb_stb_i   (wb_stb),
    .wb_cyc_i   (wb_stb),
    .wb_ack_o   (wb_ack),
    .wb_err_o   (wb_err),
    .wb_int_o   (spi_irq_out),
    .ss_pad_o   (spi_ss),
    .sclk_pad_o (spi_sck),
    .mosi_pad_o (spi_mosi),
    .miso_pad_i (spi_miso)
  );

endmodule

// File: tb/tb_spi_xip_bridge_apb.sv
// Directed bench for spi_xip_bridge_apb with a behavioural SPI flash.
// Build with XIP_PREFETCH_EN to exercise the read buffer expectations.

module tb_spi_xip_bridge_apb;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        spi_sck;
  logic [7:0]  spi_ss;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_irq_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        err;
  int          cyc;
  logic        rdy_after;

  int          s_cnt = 0;
  logic [31:0] s_rx = '0;
  logic [31:0] s_cmdaddr = '0;
  int          sck_rises = 0;
  int          ss_falls = 0;

  always #5 clock = ~clock;

  spi_xip_bridge_apb dut (
    .clock       (clock),
    .reset       (reset),
    .in_paddr    (paddr),
    .in_psel     (psel),
    .in_penable  (penable),
    .in_pprot    (pprot),
    .in_pwrite   (pwrite),
    .in_pwdata   (pwdata),
    .in_pstrb    (pstrb),
    .in_pready   (in_pready),
    .in_prdata   (in_prdata),
    .in_pslverr  (in_pslverr),
    .spi_sck     (spi_sck),
    .spi_ss      (spi_ss),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_irq_out (spi_irq_out)
  );

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] v;
    case (a)
      24'h000100: v = 8'h11;
      24'h000101: v = 8'h22;
      24'h000102: v = 8'h33;
      24'h000103: v = 8'h44;
      24'h000104: v = 8'ha1;
      24'h000105: v = 8'hb2;
      24'h000106: v = 8'hc3;
      24'h000107: v = 8'hd4;
      default:    v = a[7:0] ^ 8'h5a;
    endcase
    return v;
  endfunction

  // flash: samples MOSI on falling SCK, drives MISO after rising SCK
  always @(negedge spi_ss[0]) begin
    s_cnt = 0;
    ss_falls++;
  end

  always @(posedge spi_sck) begin
    int b;
    logic [7:0] byt;
    sck_rises++;
    if (!spi_ss[0] && s_cnt >= 32) begin
      b = s_cnt - 32;
      byt = flash_byte(s_cmdaddr[23:0] + 24'(b / 8));
      spi_miso = byt[7 - (b % 8)];
    end else begin
      spi_miso = 1'b0;
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_ss[0]) begin
      s_rx = {s_rx[30:0], spi_mosi};
      s_cnt++;
      if (s_cnt == 32) s_cmdaddr = s_rx;
    end
  end

  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     output logic [31:0] r, output logic e, output int c,
                     output logic ra);
    @(negedge clock);
    psel = 1'b1; paddr = a; pwrite = w; pwdata = d; penable = 1'b0;
    @(negedge clock);
    penable = 1'b1;
    c = 1;
    while (!in_pready && c < 2000) begin
      @(negedge clock);
      c++;
    end
    if (!in_pready) begin
      n_cmp++; n_bad++;
      $display("FAIL apb_timeout addr=%h: pready still 0 after %0d cycles, want 1", a, c);
    end
    r = in_prdata;
    e = in_pslverr;
    @(negedge clock);
    ra = in_pready;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (in_pready !== 1'b0) begin n_bad++; $display("FAIL reset_pready: got %b want 0", in_pready); end
    n_cmp++;
    if (in_prdata !== 32'h0) begin n_bad++; $display("FAIL reset_prdata: got %h want 0", in_prdata); end
    n_cmp++;
    if (in_pslverr !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr: got %b want 0", in_pslverr); end
    n_cmp++;
    if (spi_ss !== 8'hff) begin n_bad++; $display("FAIL reset_ss: got %h want ff", spi_ss); end
    n_cmp++;
    if (spi_sck !== 1'b0) begin n_bad++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
    n_cmp++;
    if (spi_irq_out !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", spi_irq_out); end
    reset = 1'b0;
  endtask

  task automatic test_xip_read;
    apb(32'h3000_0100, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (rd !== 32'h4433_2211) begin n_bad++; $display("FAIL xip_data: got %h want 44332211", rd); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL xip_slverr: got %b want 0", err); end
    n_cmp++;
    if (s_cmdaddr !== 32'h0300_0100) begin n_bad++; $display("FAIL xip_mosi: got %h want 03000100", s_cmdaddr); end
    n_cmp++;
    if (cyc < 264 || cyc > 280) begin n_bad++; $display("FAIL xip_latency: got %0d want 264..280", cyc); end
    n_cmp++;
    if (rdy_after !== 1'b0) begin n_bad++; $display("FAIL xip_resp_width: pready after resp %b want 0", rdy_after); end
    n_cmp++;
    if (spi_ss !== 8'hff) begin n_bad++; $display("FAIL xip_unsel: got %h want ff", spi_ss); end
  endtask

  task automatic test_flash_write;
    int f0;
    f0 = ss_falls;
    apb(32'h3000_0000, 1'b1, 32'hdead_beef, rd, err, cyc, rdy_after);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL fwr_slverr: got %b want 1", err); end
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL fwr_cycles: got %0d want 2", cyc); end
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL fwr_prdata: got %h want 0", rd); end
    n_cmp++;
    if (ss_falls !== f0 || spi_ss !== 8'hff) begin
      n_bad++; $display("FAIL fwr_ss: falls %0d ss %h want 0 falls, ff", ss_falls - f0, spi_ss);
    end
  endtask

  task automatic test_pass_divider;
    int f0, k0;
    f0 = ss_falls;
    k0 = sck_rises;
    apb(32'h1000_1014, 1'b1, 32'h5, rd, err, cyc, rdy_after);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL pass_wr_slverr: got %b want 0", err); end
    apb(32'h1000_1014, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (rd !== 32'h5) begin n_bad++; $display("FAIL pass_rd_div: got %h want 5", rd); end
    n_cmp++;
    if (ss_falls !== f0 || sck_rises !== k0) begin
      n_bad++; $display("FAIL pass_no_xip: ss falls %0d sck %0d want 0 0", ss_falls - f0, sck_rises - k0);
    end
  endtask

  task automatic test_out_of_range;
    apb(32'h2000_0000, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL oor_slverr: got %b want 1", err); end
    n_cmp++;
    if (rd !== 32'h0) begin n_bad++; $display("FAIL oor_prdata: got %h want 0", rd); end
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL oor_cycles: got %0d want 2", cyc); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    psel = 1'b1; paddr = 32'h3000_0104; pwrite = 1'b0; penable = 1'b0;
    @(negedge clock);
    penable = 1'b1;
    repeat (100) @(negedge clock);
    n_cmp++;
    if (spi_ss[0] !== 1'b0) begin n_bad++; $display("FAIL mid_active: ss0 %b want 0", spi_ss[0]); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (spi_ss !== 8'hff) begin n_bad++; $display("FAIL mid_ss_release: got %h want ff", spi_ss); end
    @(posedge clock);
    #1;
    n_cmp++;
    if (in_pready !== 1'b0) begin n_bad++; $display("FAIL mid_pready: got %b want 0", in_pready); end
    @(negedge clock);
    psel = 1'b0; penable = 1'b0; reset = 1'b0;
    apb(32'h3000_0104, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (rd !== 32'hd4c3_b2a1) begin n_bad++; $display("FAIL mid_after_data: got %h want d4c3b2a1", rd); end
  endtask

  task automatic test_prefetch;
    int k0;
    apb(32'h3000_0100, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (rd !== 32'h4433_2211) begin n_bad++; $display("FAIL pf_first_data: got %h want 44332211", rd); end
    apb(32'h3000_0104, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (rd !== 32'hd4c3_b2a1) begin n_bad++; $display("FAIL pf_fill_data: got %h want d4c3b2a1", rd); end
    k0 = sck_rises;
    apb(32'h3000_0106, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (rd !== 32'hd4c3_b2a1) begin n_bad++; $display("FAIL pf_again_data: got %h want d4c3b2a1", rd); end
`ifdef XIP_PREFETCH_EN
    n_cmp++;
    if (cyc !== 2) begin n_bad++; $display("FAIL pf_hit_cycles: got %0d want 2", cyc); end
    n_cmp++;
    if (sck_rises !== k0) begin n_bad++; $display("FAIL pf_hit_sck: got %0d rises want 0", sck_rises - k0); end
`else
    n_cmp++;
    if (sck_rises - k0 !== 64) begin n_bad++; $display("FAIL pf_nobuf_sck: got %0d rises want 64", sck_rises - k0); end
`endif
    apb(32'h1000_1014, 1'b1, 32'h5, rd, err, cyc, rdy_after);
    k0 = sck_rises;
    apb(32'h3000_0104, 1'b0, 32'h0, rd, err, cyc, rdy_after);
    n_cmp++;
    if (sck_rises - k0 !== 64) begin n_bad++; $display("FAIL pf_inval_sck: got %0d rises want 64", sck_rises - k0); end
    n_cmp++;
    if (rd !== 32'hd4c3_b2a1) begin n_bad++; $display("FAIL pf_inval_data: got %h want d4c3b2a1", rd); end
  endtask

  initial begin
    reset = 1'b1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 4'hf; pprot = 3'd0;
    spi_miso = 1'b0;
    test_reset;
    test_xip_read;
    test_flash_write;
    test_pass_divider;
    test_out_of_range;
    test_reset_mid;
    test_prefetch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
